data_memory_unit: RTL



---
 rtl/data_memory_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - multi-cycle word load/store stage with stall, done pulse and error flag
module data_memory_unit #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] word_q;
  logic [31:0]   din_q;
  logic          write_q;
  logic [31:0]   mem [DEPTH];

  logic        req;
  logic        req_err;
  logic        commit;
  logic [31:0] word_full;

  assign req       = mem_read | mem_write;
  assign word_full = {2'b00, addr[31:2]};
  assign req_err   = (mem_read & mem_write) | (addr[1:0] != 2'b00) |
                     (word_full >= 32'(DEPTH));
  assign commit    = (state == S_ACCESS) && (cnt == '0);
  assign stall     = req & ~done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      dout  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            word_q  <= addr[AW+1:2];
            din_q   <= din;
            write_q <= mem_write;
            // Illegal requests skip the array and complete on the next cycle
            if (req_err) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= S_ACCESS;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        S_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!write_q) dout <= mem[word_q];
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array is never reset; a reset on the commit edge suppresses the write
  always_ff @(posedge clk) begin
    if (!reset && commit && write_q) mem[word_q] <= din_q;
  end

endmodule
